template_match_multi: RTL

// - Frame-based multi-template waveform classifier, successor to the fixed 3-type matcher.
// - Scores each incoming sample pair (raw wave, derivative) against NUM_TPL template pairs.
// - Selects the best-scoring template by sequential argmax once FRAME_LEN valid samples are in.
// - Sits between the template ROM/derivative stage and the waveform-type display/control logic.

---
 rtl/template_match_multi.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/template_match_multi.sv
// Frame-based multi-template waveform classifier.
// Per-template match counters followed by a sequential argmax over scores.
module template_match_multi #(
  parameter int DATA_W    = 8,
  parameter int NUM_TPL   = 4,
  parameter int FRAME_LEN = 256,
  parameter int THR0      = 20,
  parameter int THR1      = 2,
  localparam int CNT_W    = $clog2(FRAME_LEN + 1),
  localparam int SCORE_W  = CNT_W + 1,
  localparam int IDX_W    = $clog2(NUM_TPL)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic                        wave_valid,
  input  logic [DATA_W-1:0]           wave_in,
  input  logic [DATA_W-1:0]           dwave_in,
  input  logic [NUM_TPL*DATA_W-1:0]   tpl_in,
  input  logic [NUM_TPL*DATA_W-1:0]   dtpl_in,
  output logic                        busy,
  output logic                        type_valid,
  output logic [IDX_W-1:0]            wave_type,
  output logic [SCORE_W-1:0]          best_score,
  output logic                        type_tie
);

  localparam int W1 = DATA_W + 1;
  localparam logic [W1-1:0]    T0   = W1'(THR0);
  localparam logic [W1-1:0]    T1   = W1'(THR1);
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(FRAME_LEN);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME_LEN - 1);
  localparam logic [IDX_W-1:0] ILST = IDX_W'(NUM_TPL - 1);

  typedef enum logic [1:0] {IDLE, ACC, CMP, DONE} state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt0 [NUM_TPL];
  logic [CNT_W-1:0]   cnt1 [NUM_TPL];
  logic [CNT_W-1:0]   scnt;
  logic [IDX_W-1:0]   idx;
  logic [IDX_W-1:0]   best_idx;
  logic [SCORE_W-1:0] best;
  logic [SCORE_W-1:0] score;
  logic               tie;
  logic               clr;
  logic [NUM_TPL-1:0] hit0;
  logic [NUM_TPL-1:0] hit1;

  // Widened subtraction so far-apart values never wrap into a match.
  function automatic logic [W1-1:0] adiff(
    input logic [DATA_W-1:0] a,
    input logic [DATA_W-1:0] b
  );
    logic signed [W1-1:0] d;
    d = $signed({1'b0, a}) - $signed({1'b0, b});
    return d[W1-1] ? W1'(-d) : W1'(d);
  endfunction

  always_comb begin
    hit0 = '0;
    hit1 = '0;
    for (int k = 0; k < NUM_TPL; k++) begin
      hit0[k] = adiff(tpl_in[k*DATA_W +: DATA_W], wave_in) <= T0;
      hit1[k] = adiff(dtpl_in[k*DATA_W +: DATA_W], dwave_in) <= T1;
    end
  end

  assign clr   = start && (state != CMP);
  assign busy  = (state == ACC) || (state == CMP);
  assign score = SCORE_W'(cnt0[idx]) + SCORE_W'(cnt1[idx]);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      for (int k = 0; k < NUM_TPL; k++) begin
        cnt0[k] <= '0;
        cnt1[k] <= '0;
      end
    end else if (state == ACC && wave_valid) begin
      for (int k = 0; k < NUM_TPL; k++) begin
        if (hit0[k] && cnt0[k] != FULL)
          cnt0[k] <= cnt0[k] + ONE;
        if (hit1[k] && cnt1[k] != FULL)
          cnt1[k] <= cnt1[k] + ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      scnt       <= '0;
      idx        <= '0;
      best_idx   <= '0;
      best       <= '0;
      tie        <= 1'b0;
      type_valid <= 1'b0;
      wave_type  <= '0;
      best_score <= '0;
      type_tie   <= 1'b0;
    end else begin
      type_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            scnt  <= '0;
            state <= ACC;
          end
        end
        ACC: begin
          if (start) begin
            scnt <= '0;
          end else if (wave_valid) begin
            if (scnt == LAST) begin
              scnt  <= '0;
              idx   <= '0;
              state <= CMP;
            end else begin
              scnt <= scnt + ONE;
            end
          end
        end
        CMP: begin
          // Strict compare keeps the lowest index on ties.
          if (idx == '0 || score > best) begin
            best     <= score;
            best_idx <= idx;
            tie      <= 1'b0;
          end else if (score == best) begin
            tie <= 1'b1;
          end
          if (idx == ILST)
            state <= DONE;
          else
            idx <= idx + IDX_W'(1);
        end
        DONE: begin
          wave_type  <= best_idx;
          best_score <= best;
          type_tie   <= tie;
          type_valid <= 1'b1;
          scnt       <= '0;
          state      <= start ? ACC : IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
